// File: rtl/prbs_checker_if.sv
// Stream-side bundle of the PRBS checker: the received bit stream in,
// lock/error status out.
interface prbs_checker_if;
  logic        in_valid;
  logic        in_bit;
  logic        clear;
  logic        locked;
  logic        err;
  logic [15:0] err_count;

  modport master (output in_valid, in_bit, clear,
                  input  locked, err, err_count);
  modport slave  (input  in_valid, in_bit, clear,
                  output locked, err, err_count);
endinterface

// File: rtl/prbs_checker.sv
// PRBS checker: seeds an LFSR from the received stream, verifies it for
// LOCK_COUNT bits, then flywheels on its own prediction and counts errors.
// Too many errors inside one WINDOW drops lock and reseeds.
module prbs_checker #(
  parameter int WIDTH      = 5,
  parameter int LOCK_COUNT = 16,
  parameter int ERR_LIMIT  = 4,
  parameter int WINDOW     = 64
) (
  input  logic           clk,
  input  logic           reset,
  prbs_checker_if.slave  bus
);
  localparam int WCW = $clog2(WINDOW);
  localparam int WEW = $clog2(WINDOW) + 1;
  localparam logic [3:0]     SEED_LAST = 4'(WIDTH - 1);
  localparam logic [7:0]     LOCK_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [WEW-1:0] ERR_LIM   = WEW'(ERR_LIMIT);

  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [3:0]       seed_cnt_q, seed_cnt_d;
  logic [7:0]       match_cnt_q, match_cnt_d;
  logic [WCW-1:0]   win_cnt_q, win_cnt_d;
  logic [WEW-1:0]   win_err_q, win_err_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;

  logic             pred;
  logic             mismatch;
  logic [WIDTH-1:0] s_shift_in;
  logic [WIDTH-1:0] s_shift_pred;
  logic [WEW-1:0]   win_err_base;
  logic [WEW-1:0]   win_err_inc;

  // Tap selection per LFSR length; unsupported parameters stop elaboration.
  generate
    if (WIDTH == 3) begin : g_w3
      assign pred = s_q[2] ^ s_q[1];
    end else if (WIDTH == 5) begin : g_w5
      assign pred = s_q[4] ^ s_q[2];
    end else if (WIDTH == 8) begin : g_w8
      assign pred = s_q[7] ^ s_q[5] ^ s_q[4] ^ s_q[3];
    end else begin : g_wbad
      $error("prbs_checker: WIDTH must be 3, 5 or 8");
      assign pred = 1'b0;
    end
    if (LOCK_COUNT < 1 || LOCK_COUNT > 255) begin : g_lcbad
      $error("prbs_checker: LOCK_COUNT out of range 1..255");
    end
    if (WINDOW < 8 || WINDOW > 1024 || (WINDOW & (WINDOW - 1)) != 0) begin : g_wnbad
      $error("prbs_checker: WINDOW must be a power of 2 in 8..1024");
    end
    if (ERR_LIMIT < 1 || ERR_LIMIT > WINDOW) begin : g_elbad
      $error("prbs_checker: ERR_LIMIT out of range 1..WINDOW");
    end
  endgenerate

  assign mismatch     = bus.in_bit ^ pred;
  assign s_shift_in   = {bus.in_bit, s_q[WIDTH-1:1]};
  assign s_shift_pred = {pred, s_q[WIDTH-1:1]};
  // Window error tally restarts on the first bit of every WINDOW-bit window.
  assign win_err_base = (win_cnt_q == '0) ? '0 : win_err_q;
  assign win_err_inc  = win_err_base + 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= SEED;
    else       state_q <= state_d;
  end

  // Next-state logic; only accepted bits move the FSM.
  always_comb begin
    state_d = state_q;
    if (bus.in_valid) begin
      case (state_q)
        SEED:    if (seed_cnt_q == SEED_LAST && s_shift_in != '0) state_d = VERIFY;
        VERIFY:  if (mismatch) state_d = SEED;
                 else if (match_cnt_q == LOCK_LAST) state_d = LOCKED;
        LOCKED:  if (mismatch && win_err_inc == ERR_LIM) state_d = SEED;
        default: state_d = SEED;
      endcase
    end
  end

  // Datapath and output next values.
  always_comb begin
    s_d         = s_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_cnt_d   = err_cnt_q;
    err_d       = 1'b0;
    locked_d    = (state_d == LOCKED);
    if (bus.in_valid) begin
      case (state_q)
        SEED: begin
          s_d        = s_shift_in;
          seed_cnt_d = (seed_cnt_q == SEED_LAST) ? '0 : seed_cnt_q + 1'b1;
        end
        VERIFY: begin
          s_d        = s_shift_in;
          seed_cnt_d = '0;
          if (mismatch || match_cnt_q == LOCK_LAST) begin
            match_cnt_d = '0;
            win_cnt_d   = '0;
            win_err_d   = '0;
          end else begin
            match_cnt_d = match_cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          // Flywheel: one corrupted bit must not poison later predictions.
          s_d       = s_shift_pred;
          win_cnt_d = win_cnt_q + 1'b1;
          win_err_d = mismatch ? win_err_inc : win_err_base;
          if (mismatch) begin
            err_d     = 1'b1;
            err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 1'b1;
          end
          if (state_d == SEED) begin
            seed_cnt_d  = '0;
            match_cnt_d = '0;
            win_cnt_d   = '0;
            win_err_d   = '0;
          end
        end
        default: ;
      endcase
    end
    if (bus.clear) err_cnt_d = '0;
  end

  // Datapath registers; reset overrides valid and clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q         <= '0;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= '0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      s_q         <= s_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      err_q       <= err_d;
      locked_q    <= locked_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_cnt_q;
endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker with default parameters (WIDTH=5, LOCK_COUNT=16,
// ERR_LIMIT=4, WINDOW=64). A reference model built on bit history and
// window arithmetic predicts locked/err/err_count after every edge.
module tb_prbs_checker;
  localparam int W  = 5;
  localparam int LC = 16;
  localparam int EL = 4;
  localparam int WN = 64;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  prbs_checker_if bus ();
  prbs_checker dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Generator: team LFSR started from all-ones; next bit is the XOR of the
  // bits 1 and 3 positions back (taps S[4]^S[2] of the 5-bit register).
  bit g_hist[$];
  // Reference model.
  bit m_hist[$];
  int m_mode;              // 0 seed, 1 verify, 2 locked
  int m_seen, m_run, m_idx, m_win, m_errcnt;
  bit m_err, m_locked;

  function automatic bit hist_pred(input bit h[$]);
    return h[h.size()-1] ^ h[h.size()-3];
  endfunction

  task automatic gen_bit(output bit b);
    b = hist_pred(g_hist);
    g_hist.push_back(b);
    void'(g_hist.pop_front());
  endtask

  task automatic model_push(input bit b);
    m_hist.push_back(b);
    void'(m_hist.pop_front());
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < W; i++) m_hist.push_back(1'b0);
    m_mode = 0; m_seen = 0; m_run = 0; m_idx = 0; m_win = 0;
    m_errcnt = 0; m_err = 0; m_locked = 0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit c, input bit r);
    bit p;
    bit any;
    if (r) begin
      model_reset();
      return;
    end
    m_err = 0;
    if (v) begin
      p = hist_pred(m_hist);
      case (m_mode)
        0: begin
          model_push(b);
          m_seen++;
          if (m_seen == W) begin
            m_seen = 0;
            any = 0;
            foreach (m_hist[i]) any |= m_hist[i];
            if (any) begin m_mode = 1; m_run = 0; end
          end
        end
        1: begin
          model_push(b);
          if (b == p) begin
            m_run++;
            if (m_run == LC) begin m_mode = 2; m_idx = 0; m_win = 0; end
          end else begin
            m_mode = 0; m_seen = 0; m_run = 0;
          end
        end
        default: begin
          model_push(p);
          if (m_idx % WN == 0) m_win = 0;
          m_idx++;
          if (b != p) begin
            m_err = 1;
            m_win++;
            if (m_errcnt < 65535) m_errcnt++;
            if (m_win == EL) begin m_mode = 0; m_seen = 0; m_run = 0; end
          end
        end
      endcase
    end
    if (c) m_errcnt = 0;
    m_locked = (m_mode == 2);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, update the model, compare.
  task automatic tick(input bit v, input bit b, input bit c, input bit r);
    bus.in_valid = v; bus.in_bit = b; bus.clear = c; reset = r;
    @(posedge clk);
    model_step(v, b, c, r);
    #1;
    chk("locked",    32'(bus.locked),    32'(m_locked));
    chk("err",       32'(bus.err),       32'(m_err));
    chk("err_count", 32'(bus.err_count), 32'(m_errcnt));
  endtask

  task automatic drive(input bit flip);
    bit b;
    gen_bit(b);
    tick(1'b1, b ^ flip, 1'b0, 1'b0);
  endtask

  // Feed clean bits until lock; returns number of valid bits used (-1 on timeout).
  task automatic lock_count(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      drive(1'b0);
      if (bus.locked === 1'b1) begin n = i; break; end
    end
  endtask

  initial begin
    int n;
    bit b;
    g_hist.delete();
    for (int i = 0; i < W; i++) g_hist.push_back(1'b1);
    model_reset();
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.clear = 1'b0; reset = 1'b1;

    // Reset state
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_locked", 32'(bus.locked), 32'd0);
    chk("reset_count",  32'(bus.err_count), 32'd0);

    // Lock from clean stream after exactly WIDTH+LOCK_COUNT bits
    lock_count(n);
    chk("lock_bits", n, W + LC);
    for (int i = n; i < 1000; i++) drive(1'b0);
    chk("clean_1000_count", 32'(bus.err_count), 32'd0);
    chk("clean_1000_locked", 32'(bus.locked), 32'd1);

    // Single error
    drive(1'b1);
    chk("single_err", 32'(bus.err), 32'd1);
    chk("single_count", 32'(bus.err_count), 32'd1);
    drive(1'b0);
    chk("single_err_gone", 32'(bus.err), 32'd0);
    chk("single_locked", 32'(bus.locked), 32'd1);

    // Loss of lock: 4 errors inside one window
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < WN && (m_idx % WN) != 0; i++) drive(1'b0);
    for (int i = 0; i < 16; i++) begin
      drive(i % 5 == 0);
      if (i < 15) chk("lol_locked_hold", 32'(bus.locked), 32'd1);
      if (i == 15) chk("lol_locked_fall", 32'(bus.locked), 32'd0);
      if (i == 15) chk("lol_count", 32'(bus.err_count), 32'd4);
    end
    lock_count(n);
    chk("relock_bits", n, W + LC);

    // Reset mid-LOCKED
    gen_bit(b);
    tick(1'b1, b, 1'b0, 1'b1);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_count",  32'(bus.err_count), 32'd0);
    lock_count(n);
    chk("rst_relock_bits", n, W + LC);

    // Saturation and clear priority
    force dut.err_cnt_q = 16'hFFFF;
    #1 release dut.err_cnt_q;
    m_errcnt = 65535;
    drive(1'b1);
    chk("sat_count", 32'(bus.err_count), 32'hFFFF);
    chk("sat_err", 32'(bus.err), 32'd1);
    gen_bit(b);
    tick(1'b1, ~b, 1'b1, 1'b0);
    chk("clear_count", 32'(bus.err_count), 32'd0);
    chk("clear_err", 32'(bus.err), 32'd1);

    // All-zero input never leaves SEED
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("zero_locked", 32'(bus.locked), 32'd0);
    chk("zero_mode", m_mode, 0);

    // Clean stream with random valid gaps
    n = 0;
    for (int i = 0; i < 400 && bus.locked !== 1'b1; i++) begin
      if ($urandom_range(0, 2) == 0) tick(1'b0, 1'($urandom), 1'b0, 1'b0);
      else drive(1'b0);
      n++;
    end
    chk("gap_locked", 32'(bus.locked), 32'd1);
    chk("gap_count", 32'(bus.err_count), 32'd0);

    // Randomized mix: gaps, corrupted bits, clears and rare resets
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r < 2) begin
        gen_bit(b);
        tick(1'b1, b, 1'b0, 1'b1);
      end else if (r < 40) begin
        tick(1'b0, 1'($urandom), r < 6, 1'b0);
      end else begin
        gen_bit(b);
        tick(1'b1, b ^ ($urandom_range(0, 39) == 0), r < 44, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
